// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin tenure arbiter.
// Holds the FSM state encoding and a one-hot to index decoder sized for up to 16 agents.
package wrr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_AGENTS = 16;
  localparam int unsigned MAX_IDX_W  = 4;

  // OR-reduction decode: exact for one-hot input, 0 for an all-zero vector.
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_AGENTS-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_AGENTS); i++) begin
      if (vec[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_tenure_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after i_start, wrapping at N.
// Candidate indices are precomputed per scan slot so the search is a flat priority chain.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] w_sum;
      assign w_sum       = {1'b0, i_start} + (IW+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
    end
  endgenerate

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_found && i_req[w_cand[k]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/wrr_tenure_arbiter.sv
// Weighted round-robin arbiter for one shared resource: registered one-hot grant held until the
// owner pulses eot, with per-agent consecutive-tenure credit and an optional hold-time watchdog.
module wrr_tenure_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WW       = 3,
  parameter int MAX_HOLD = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         eot,
  input  logic [N*WW-1:0]      weight,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [$clog2(N)-1:0] timeout_id
);

  localparam int IW = $clog2(N);
  localparam int CW = WW + 1;
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e    r_state,      w_state_next;
  logic [N-1:0]  r_gnt,        w_gnt_next;
  logic [IW-1:0] r_last,       w_last_next;
  logic [CW-1:0] r_credit,     w_credit_next;
  logic [HW-1:0] r_hold,       w_hold_next;
  logic          r_timeout,    w_timeout_next;
  logic [IW-1:0] r_timeout_id, w_timeout_id_next;

  logic [IW-1:0] w_start;
  logic          w_found;
  logic [IW-1:0] w_scan_idx;
  logic [WW-1:0] w_last_wt;
  logic [CW-1:0] w_last_lim;
  logic          w_keep_last;
  logic [IW-1:0] w_win;
  logic [CW-1:0] w_credit_inc;
  logic [IW-1:0] w_owner;
  logic [WW-1:0] w_owner_wt;
  logic          w_eot_hit;
  logic          w_wd_hit;

  assign w_start = (r_last == IW'(N - 1)) ? '0 : r_last + 1'b1;

  rr_pick #(
    .N (N)
  ) u_pick (
    .i_req   (req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_scan_idx)
  );

  // A zero weight still entitles the agent to one tenure per turn.
  assign w_last_wt    = weight[int'(r_last)*WW +: WW];
  assign w_last_lim   = (w_last_wt == '0) ? CW'(1) : {1'b0, w_last_wt};
  assign w_keep_last  = req[r_last] && (r_credit < w_last_lim);
  assign w_win        = w_keep_last ? r_last : w_scan_idx;
  // Saturate so a lone re-requester can never wrap back below its weight.
  assign w_credit_inc = (r_credit == '1) ? r_credit : r_credit + 1'b1;

  assign w_owner    = IW'(onehot2idx(MAX_AGENTS'(r_gnt)));
  assign w_owner_wt = weight[int'(w_owner)*WW +: WW];
  assign w_eot_hit  = |(eot & r_gnt);
  assign w_wd_hit   = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

  always_comb begin
    w_state_next      = r_state;
    w_gnt_next        = r_gnt;
    w_last_next       = r_last;
    w_credit_next     = r_credit;
    w_hold_next       = r_hold;
    w_timeout_next    = 1'b0;
    w_timeout_id_next = r_timeout_id;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_next        = '0;
          w_gnt_next[w_win] = 1'b1;
          w_state_next      = BUSY;
          w_hold_next       = '0;
          w_credit_next     = (w_win == r_last) ? w_credit_inc : CW'(1);
        end
      end
      BUSY: begin
        w_hold_next = (r_hold == '1) ? r_hold : r_hold + 1'b1;
        // eot is checked first so it wins over a coincident watchdog expiry.
        if (w_eot_hit) begin
          w_gnt_next   = '0;
          w_state_next = IDLE;
          w_last_next  = w_owner;
        end else if (w_wd_hit) begin
          w_gnt_next        = '0;
          w_state_next      = IDLE;
          w_last_next       = w_owner;
          w_credit_next     = {1'b0, w_owner_wt};
          w_timeout_next    = 1'b1;
          w_timeout_id_next = w_owner;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_last       <= IW'(N - 1);
      r_credit     <= '0;
      r_hold       <= '0;
      r_timeout    <= 1'b0;
      r_timeout_id <= '0;
    end else begin
      r_state      <= w_state_next;
      r_gnt        <= w_gnt_next;
      r_last       <= w_last_next;
      r_credit     <= w_credit_next;
      r_hold       <= w_hold_next;
      r_timeout    <= w_timeout_next;
      r_timeout_id <= w_timeout_id_next;
    end
  end

  assign gnt        = r_gnt;
  assign busy       = |r_gnt;
  assign owner_id   = w_owner;
  assign timeout    = r_timeout;
  assign timeout_id = r_timeout_id;

endmodule
